noise_arb_ctrl: RTL and testbench

Controller and arbiter for the AWGN noise generator in the SERDES channel model. It owns the generator's 128-entry CDF threshold table load path and the run/stop sequencing of the generator enable. It buffers generated 8-bit signed noise samples in a small FIFO with generator throttling, and shares them round-robin between NUM_REQ channel lanes. It sits between the UART-driven config registers and the per-lane noise adders.

---
 rtl/noise_arb_ctrl_if.sv | 39 +++
 rtl/noise_arb_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_noise_arb_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/noise_arb_ctrl_if.sv
// Bus bundle for noise_arb_ctrl: config/table load path, generator handshake, lane
// request/grant and statistics.
//   master : drives start/stop, cfg_*, gen_valid/gen_noise and req; observes the rest
//   slave  : the controller side (noise_arb_ctrl)
interface noise_arb_ctrl_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic                    start;
    logic                    stop;
    logic                    cfg_we;
    logic [6:0]              cfg_addr;
    logic [63:0]             cfg_data;
    logic                    tbl_we;
    logic [6:0]              tbl_addr;
    logic [63:0]             tbl_data;
    logic                    gen_en;
    logic                    gen_valid;
    logic [7:0]              gen_noise;
    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0]      gnt;
    logic [7:0]              noise_out;
    logic                    busy;
    logic                    tbl_loaded;
    logic                    cfg_err;
    logic [16*NUM_REQ-1:0]   grant_cnt;
    logic [15:0]             drop_cnt;

    modport master (
        output start, stop, cfg_we, cfg_addr, cfg_data, gen_valid, gen_noise, req,
        input  tbl_we, tbl_addr, tbl_data, gen_en, gnt, noise_out, busy, tbl_loaded,
               cfg_err, grant_cnt, drop_cnt
    );

    modport slave (
        input  start, stop, cfg_we, cfg_addr, cfg_data, gen_valid, gen_noise, req,
        output tbl_we, tbl_addr, tbl_data, gen_en, gnt, noise_out, busy, tbl_loaded,
               cfg_err, grant_cnt, drop_cnt
    );
endinterface

// File: rtl/noise_arb_ctrl.sv
// AWGN noise generator controller and sample arbiter.
// - Forwards CDF table writes to the generator while idle and tracks which of the 128
//   entries have been written (tbl_loaded).
// - Sequences the generator enable through IDLE -> RUN -> DRAIN -> IDLE.
// - Buffers generated samples in a DEPTH-entry FIFO; gen_en is throttled so that more than
//   SKID slots stay free to absorb samples already in the generator pipeline.
// - Hands samples round-robin to NUM_REQ lanes, one registered grant per cycle.
// Ports:
//   clk, rstn : clock and asynchronous active-low reset
//   bus_io    : noise_arb_ctrl_if slave modport carrying all other signals
// Optional feature: define NOISE_ARB_STATS_EN to build the 16-bit saturating per-lane grant
// counters and the dropped-sample counter; otherwise grant_cnt/drop_cnt read as zero.
module noise_arb_ctrl #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned SKID    = 2
) (
    input logic             clk,
    input logic             rstn,
    noise_arb_ctrl_if.slave bus_io
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned LgW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned SumW = LgW + 1;
    // Wide enough to hold SKID + 1 without wrapping.
    localparam int unsigned DrW  = $clog2(SKID + 2);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    // Control FSM state and registered outputs.
    state_e          state_q;
    logic [DrW-1:0]  drain_cnt_q;
    logic            gen_en_q;
    logic            busy_q;
    logic            cfg_err_q;
    logic            tbl_we_q;
    logic [6:0]      tbl_addr_q;
    logic [63:0]     tbl_data_q;
    logic [127:0]    mask_q;

    // Sample FIFO.
    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;

    // Arbiter.
    logic [NUM_REQ-1:0] gnt_q;
    logic [7:0]         noise_q;
    logic [LgW-1:0]     last_q;

    logic               tbl_loaded;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic [31:0]        free_slots;
    logic               room_ok;
    logic               drain_done;
    logic [LgW-1:0]     win_idx;
    logic [SumW-1:0]    sum_c;

    assign tbl_loaded = &mask_q;
    assign fifo_full  = (count_q == CntW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push       = bus_io.gen_valid && !fifo_full;
    // A sample pushed this cycle is not poppable until next cycle since count_q lags.
    assign pop        = !fifo_empty && (|bus_io.req);
    assign free_slots = 32'(DEPTH) - 32'(count_q);
    assign room_ok    = free_slots > 32'(SKID);
    // drain_cnt_q counts DRAIN cycles already completed; +1 includes the current one.
    assign drain_done = ((drain_cnt_q + DrW'(1)) >= DrW'(SKID)) && fifo_empty;

    // Round-robin pick: scan from last_q+NUM_REQ down to last_q+1 so the nearest
    // requester after the last winner is the one left standing.
    always_comb begin
        win_idx = last_q;
        sum_c   = '0;
        for (int k = int'(NUM_REQ); k >= 1; k--) begin
            sum_c = {1'b0, last_q} + SumW'(k);
            if (sum_c >= SumW'(NUM_REQ)) begin
                sum_c = sum_c - SumW'(NUM_REQ);
            end
            if (bus_io.req[sum_c[LgW-1:0]]) begin
                win_idx = sum_c[LgW-1:0];
            end
        end
    end

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            gen_en_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
            tbl_we_q    <= 1'b0;
            tbl_addr_q  <= '0;
            tbl_data_q  <= '0;
            mask_q      <= '0;
        end else begin
            tbl_we_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    gen_en_q <= 1'b0;
                    if (bus_io.cfg_we) begin
                        tbl_we_q                <= 1'b1;
                        tbl_addr_q              <= bus_io.cfg_addr;
                        tbl_data_q              <= bus_io.cfg_data;
                        mask_q[bus_io.cfg_addr] <= 1'b1;
                    end
                    if (bus_io.start) begin
                        if (tbl_loaded) begin
                            state_q  <= StRun;
                            busy_q   <= 1'b1;
                            gen_en_q <= room_ok;
                        end else begin
                            cfg_err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (bus_io.cfg_we) begin
                        cfg_err_q <= 1'b1;
                    end
                    // stop wins over a simultaneous start; start is ignored here anyway.
                    if (bus_io.stop) begin
                        state_q     <= StDrain;
                        gen_en_q    <= 1'b0;
                        drain_cnt_q <= '0;
                    end else begin
                        gen_en_q <= room_ok;
                    end
                end
                StDrain: begin
                    gen_en_q <= 1'b0;
                    if (bus_io.cfg_we) begin
                        cfg_err_q <= 1'b1;
                    end
                    if (drain_done) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else if (drain_cnt_q != DrW'(SKID)) begin
                        drain_cnt_q <= drain_cnt_q + DrW'(1);
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    busy_q   <= 1'b0;
                    gen_en_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage and registered grant.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            gnt_q    <= '0;
            noise_q  <= '0;
            last_q   <= LgW'(NUM_REQ - 1);
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus_io.gen_noise;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
                noise_q  <= mem_q[rd_ptr_q];
                gnt_q    <= NUM_REQ'(1) << win_idx;
                last_q   <= win_idx;
            end else begin
                gnt_q <= '0;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef NOISE_ARB_STATS_EN
    logic [15:0] grant_cnt_q [NUM_REQ];
    logic [15:0] drop_cnt_q;
    logic        drop;

    assign drop = bus_io.gen_valid && fifo_full;

    // Counters move on the same edge that registers the grant or loses the sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                grant_cnt_q[i] <= '0;
            end
            drop_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (pop && (win_idx == LgW'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_gcnt
        assign bus_io.grant_cnt[16*g +: 16] = grant_cnt_q[g];
    end
    assign bus_io.drop_cnt = drop_cnt_q;
`else
    assign bus_io.grant_cnt = '0;
    assign bus_io.drop_cnt  = '0;
`endif

    assign bus_io.tbl_we     = tbl_we_q;
    assign bus_io.tbl_addr   = tbl_addr_q;
    assign bus_io.tbl_data   = tbl_data_q;
    assign bus_io.gen_en     = gen_en_q;
    assign bus_io.gnt        = gnt_q;
    assign bus_io.noise_out  = noise_q;
    assign bus_io.busy       = busy_q;
    assign bus_io.tbl_loaded = tbl_loaded;
    assign bus_io.cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_noise_arb_ctrl.sv
// Directed plus randomized bench for noise_arb_ctrl with a queue-based reference model.
module tb_noise_arb_ctrl;
    localparam int NUM_REQ = 4;
    localparam int DEPTH   = 8;
    localparam int SKID    = 2;
`ifdef NOISE_ARB_STATS_EN
    localparam bit StatsOn = 1'b1;
`else
    localparam bit StatsOn = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    noise_arb_ctrl_if #(.NUM_REQ(NUM_REQ)) nif ();

    noise_arb_ctrl #(
        .NUM_REQ (NUM_REQ),
        .DEPTH   (DEPTH),
        .SKID    (SKID)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .bus_io (nif)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: 0 idle, 1 run, 2 drain.
    int           m_state;
    int           m_drain_cycles;
    byte          m_q[$];
    int           m_last;
    bit [127:0]   m_mask;
    bit           m_tbl_we;
    bit [6:0]     m_tbl_addr;
    bit [63:0]    m_tbl_data;
    bit           m_gen_en;
    bit           m_cfg_err;
    bit [NUM_REQ-1:0] m_gnt;
    bit [7:0]     m_noise;
    int           m_gcnt[NUM_REQ];
    int           m_drop;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_drain_cycles = 0; m_q.delete(); m_last = NUM_REQ - 1;
        m_mask = '0; m_tbl_we = 0; m_tbl_addr = '0; m_tbl_data = '0;
        m_gen_en = 0; m_cfg_err = 0; m_gnt = '0; m_noise = '0; m_drop = 0;
        for (int i = 0; i < NUM_REQ; i++) m_gcnt[i] = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int cnt    = m_q.size();
        int ns     = m_state;
        bit loaded = &m_mask;
        int lane;
        m_tbl_we  = 0;
        m_cfg_err = 0;
        m_gnt     = '0;
        if (cnt > 0 && nif.req != '0) begin
            lane = m_last;
            for (int k = 1; k <= NUM_REQ; k++) begin
                lane = (m_last + k) % NUM_REQ;
                if (nif.req[lane]) break;
            end
            m_gnt[lane] = 1'b1;
            m_noise     = m_q.pop_front();
            m_last      = lane;
            if (m_gcnt[lane] < 65535) m_gcnt[lane]++;
        end
        if (nif.gen_valid) begin
            if (cnt < DEPTH) m_q.push_back(nif.gen_noise);
            else if (m_drop < 65535) m_drop++;
        end
        case (m_state)
            0: begin
                if (nif.cfg_we) begin
                    m_tbl_we = 1; m_tbl_addr = nif.cfg_addr; m_tbl_data = nif.cfg_data;
                    m_mask[nif.cfg_addr] = 1'b1;
                end
                if (nif.start) begin
                    if (loaded) ns = 1;
                    else m_cfg_err = 1;
                end
            end
            1: begin
                if (nif.cfg_we) m_cfg_err = 1;
                if (nif.stop) begin
                    ns = 2;
                    m_drain_cycles = 0;
                end
            end
            default: begin
                if (nif.cfg_we) m_cfg_err = 1;
                m_drain_cycles++;
                if (m_drain_cycles >= SKID && cnt == 0) ns = 0;
            end
        endcase
        m_gen_en = (ns == 1) && ((DEPTH - cnt) > SKID);
        m_state  = ns;
    endtask

    task automatic compare_all();
        logic [63:0] gexp = '0;
        for (int i = 0; i < NUM_REQ; i++) gexp[16*i +: 16] = StatsOn ? m_gcnt[i][15:0] : 16'd0;
        chk("gnt", nif.gnt, m_gnt);
        chk("noise_out", nif.noise_out, m_noise);
        chk("gen_en", nif.gen_en, m_gen_en);
        chk("busy", nif.busy, m_state != 0);
        chk("tbl_we", nif.tbl_we, m_tbl_we);
        chk("tbl_addr", nif.tbl_addr, m_tbl_addr);
        chk("tbl_data", nif.tbl_data, m_tbl_data);
        chk("tbl_loaded", nif.tbl_loaded, &m_mask);
        chk("cfg_err", nif.cfg_err, m_cfg_err);
        chk("grant_cnt", nif.grant_cnt, gexp);
        chk("drop_cnt", nif.drop_cnt, StatsOn ? 64'(m_drop[15:0]) : 64'd0);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        nif.start = 0; nif.stop = 0; nif.cfg_we = 0; nif.cfg_addr = '0; nif.cfg_data = '0;
        nif.gen_valid = 0; nif.gen_noise = '0; nif.req = '0;
    endtask

    initial begin
        int g0;
        int dcyc;
        quiet();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;

        // Load all but the last entry; start must be refused.
        for (int a = 0; a < 127; a++) begin
            nif.cfg_we = 1; nif.cfg_addr = 7'(a); nif.cfg_data = {$urandom, $urandom};
            step();
        end
        quiet();
        nif.start = 1;
        step();
        chk("start_unloaded_err", nif.cfg_err, 1);
        chk("start_unloaded_busy", nif.busy, 0);
        quiet();
        nif.cfg_we = 1; nif.cfg_addr = 7'd127; nif.cfg_data = {$urandom, $urandom};
        step();
        chk("tbl_loaded_rise", nif.tbl_loaded, 1);
        quiet();
        nif.start = 1;
        step();
        chk("start_gen_en", nif.gen_en, 1);
        chk("start_busy", nif.busy, 1);
        quiet();

        // Ramp with all lanes requesting: lane order 0,1,2,3,0...
        nif.req = 4'b1111;
        for (int k = 1; k <= 10; k++) begin
            nif.gen_valid = 1; nif.gen_noise = 8'(k);
            step();
            if (k >= 2) begin
                chk("ramp_gnt", nif.gnt, 64'(1) << ((k - 2) % NUM_REQ));
                chk("ramp_noise", nif.noise_out, 64'(k - 1));
            end
        end
        nif.gen_valid = 0;
        step();

        // Fill with no requesters, then three samples into a full FIFO.
        nif.req = '0;
        nif.gen_valid = 1;
        for (int k = 0; k < 11; k++) begin
            nif.gen_noise = 8'($urandom);
            step();
        end
        chk("full_gen_en", nif.gen_en, 0);
        chk("drop_three", nif.drop_cnt, StatsOn ? 3 : 0);

        // Leave five queued, then stop and drain to lane 0.
        nif.gen_valid = 0;
        nif.req = 4'b0001;
        repeat (3) step();
        nif.stop = 1;
        step();
        nif.stop = 0;
        g0 = (nif.gnt == 4'b0001) ? 1 : 0;
        chk("stop_gen_en", nif.gen_en, 0);
        chk("stop_busy", nif.busy, 1);
        dcyc = 0;
        while (nif.busy === 1'b1 && dcyc < 40) begin
            step();
            dcyc++;
            if (nif.gnt == 4'b0001) g0++;
        end
        chk("drain_idle", nif.busy, 0);
        chk("drain_grants", g0, 5);
        chk("drain_min_cycles", (dcyc + 1) > SKID, 1);

        // Config write while running is rejected.
        quiet();
        nif.start = 1;
        step();
        quiet();
        nif.cfg_we = 1; nif.cfg_addr = 7'd5; nif.cfg_data = 64'hDEAD_BEEF;
        step();
        chk("run_cfg_err", nif.cfg_err, 1);
        chk("run_no_tbl_we", nif.tbl_we, 0);
        quiet();

        // Randomized traffic.
        for (int n = 0; n < 800; n++) begin
            nif.req       = 4'($urandom);
            nif.gen_valid = ($urandom_range(3) != 0);
            nif.gen_noise = 8'($urandom);
            nif.start     = ($urandom_range(15) == 0);
            nif.stop      = ($urandom_range(19) == 0);
            nif.cfg_we    = ($urandom_range(7) == 0);
            nif.cfg_addr  = 7'($urandom);
            nif.cfg_data  = {$urandom, $urandom};
            step();
        end

        // Settle to idle, restart, then reset asynchronously mid-run.
        quiet();
        nif.req = 4'b1111;
        nif.stop = 1;
        repeat (30) step();
        quiet();
        nif.start = 1;
        step();
        chk("rerun_busy", nif.busy, 1);
        quiet();
        nif.gen_valid = 1;
        repeat (3) step();
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        quiet();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rstn = 1'b1;
        nif.start = 1;
        step();
        chk("post_reset_err", nif.cfg_err, 1);
        chk("post_reset_idle", nif.busy, 0);
        quiet();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
